addsub_seq_flags: RTL and testbench

- Parametrised, sequential successor to the 16-bit structural ripple-carry adder with status flags.
- Adds or subtracts two WIDTH-bit operands SLICE bits per clock, rippling the carry between slices through a carry register.
- Produces result plus carry/sign/parity/zero/overflow flags behind a valid/ready handshake on both sides.
- Sits in the datapath wherever a full-width single-cycle adder is too costly in area or timing.

---
 rtl/addsub_seq_flags.sv | 194 +++++++++++++++++++
 tb/tb_addsub_seq_flags.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq_flags.sv
// Sequential add/subtract unit that processes SLICE bits per clock and reports carry/sign/parity/zero/overflow.
// Optional macro SATURATE_EN clamps z to the signed max/min on signed overflow.
module addsub_seq_flags #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             sign,
    output logic             parity,
    output logic             zero,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               carry_q, carry_d;
    logic               sign_q, sign_d;
    logic               parity_q, parity_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [SLICE-1:0]   a_slice;
    logic [SLICE-1:0]   b_slice;
    logic [SLICE:0]     slice_sum;
    logic [WIDTH-1:0]   z_merged;
    logic [WIDTH-1:0]   z_final;
    logic               ovf_raw;

    // Select the active slice of each latched operand and add it with the rippled carry.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_slice = a_q[i*SLICE +: SLICE];
                b_slice = b_q[i*SLICE +: SLICE];
            end
        end
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, cy_q};
    end

    // The result as it will look once the current slice sum is written back.
    always_comb begin
        z_merged = z_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                z_merged[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            end
        end
        ovf_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (z_merged[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SATURATE_EN
        if (ovf_raw) begin
            z_final = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            z_final = z_merged;
        end
`else
        z_final = z_merged;
`endif
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cy_d        = cy_q;
        cnt_d       = cnt_q;
        z_d         = z_q;
        carry_d     = carry_q;
        sign_d      = sign_q;
        parity_d    = parity_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid) begin
                    a_d        = x;
                    b_d        = sub ? ~y : y;
                    cy_d       = sub;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                cy_d  = slice_sum[SLICE];
                cnt_d = cnt_q + CNT_W'(1);
                z_d   = z_merged;
                if (cnt_q == LAST_CNT) begin
                    // Flags come from the final (possibly clamped) result; carry stays raw.
                    z_d         = z_final;
                    carry_d     = slice_sum[SLICE];
                    sign_d      = z_final[WIDTH-1];
                    parity_d    = ^z_final;
                    zero_d      = (z_final == '0);
                    overflow_d  = ovf_raw;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            z_q         <= '0;
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            parity_q    <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            carry_q     <= carry_d;
            sign_q      <= sign_d;
            parity_q    <= parity_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign carry     = carry_q;
    assign sign      = sign_q;
    assign parity    = parity_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_addsub_seq_flags.sv
// Self-checking bench for addsub_seq_flags: 16/4 instance against an arithmetic model, plus a 32/8 instance.
// Honours SATURATE_EN the same way the design does.
module tb_addsub_seq_flags;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [15:0] x, y, z;
    logic        carry, sign, parity, zero, overflow;

    logic        in_valid_w, in_ready_w, sub_w, out_valid_w, out_ready_w;
    logic [31:0] x_w, y_w, z_w;
    logic        carry_w, sign_w, parity_w, zero_w, overflow_w;

    typedef struct packed {
        logic [63:0] z;
        logic [4:0]  f;
    } res_t;

    res_t        exp_q[$];
    int          checks;
    int          errors;
    int          cyc;
    int          accept_cyc;
    logic        prev_valid;

    addsub_seq_flags #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .carry(carry), .sign(sign), .parity(parity), .zero(zero), .overflow(overflow)
    );

    addsub_seq_flags #(.WIDTH(32), .SLICE(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .x(x_w), .y(y_w), .sub(sub_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .z(z_w), .carry(carry_w), .sign(sign_w), .parity(parity_w), .zero(zero_w), .overflow(overflow_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain w-bit two's-complement arithmetic, subtraction as x + ~y + 1.
    function automatic res_t model(input int w, input logic [63:0] xv, input logic [63:0] yv, input logic s);
        logic [64:0] mask, a, b, full, zz;
        logic        c, ov;
        res_t        r;
        mask = (65'd1 << w) - 65'd1;
        a    = {1'b0, xv} & mask;
        b    = s ? (~{1'b0, yv} & mask) : ({1'b0, yv} & mask);
        full = a + b + {64'd0, s};
        zz   = full & mask;
        c    = full[w];
        ov   = (a[w-1] == b[w-1]) && (zz[w-1] != a[w-1]);
`ifdef SATURATE_EN
        if (ov) zz = a[w-1] ? (65'd1 << (w-1)) : ((65'd1 << (w-1)) - 65'd1);
`endif
        r.z = zz[63:0];
        r.f = {c, zz[w-1], ^zz, (zz == 65'd0), ov};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare process: every cycle the 16-bit result is valid it must match the head of the model queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("z", 64'(z), exp_q[0].z);
                    checkOutput("flags", 64'({carry, sign, parity, zero, overflow}), 64'(exp_q[0].f));
                    checkOutput("in_ready_while_valid", 64'(in_ready), 64'd0);
                    if (!prev_valid) checkOutput("latency", 64'(cyc - accept_cyc), 64'd4);
                end
            end
            prev_valid <= out_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv, input logic sv);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        x = xv; y = yv; sub = sv; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        #1;
        if (!ok) begin
            checkOutput("accept_timeout", 64'(ok), 64'd1);
        end else begin
            accept_cyc = cyc;
            exp_q.push_back(model(16, {48'd0, xv}, {48'd0, yv}, sv));
        end
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom);
    endtask

    task automatic waitValid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        if (!seen) checkOutput("valid_timeout", 64'(seen), 64'd1);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic runDirected(input string name, input logic [15:0] xv, input logic [15:0] yv,
                               input logic sv, input logic [15:0] ez, input logic [4:0] ef);
        out_ready = 1'b0;
        applyStimulus(xv, yv, sv);
        waitValid();
        checkOutput({name, "_z"}, 64'(z), 64'(ez));
        checkOutput({name, "_flags"}, 64'({carry, sign, parity, zero, overflow}), 64'(ef));
        out_ready = 1'b1;
        waitDrain();
    endtask

    task automatic runWide(input logic [31:0] xv, input logic [31:0] yv, input logic sv,
                           input logic [31:0] ez, input logic [4:0] ef);
        bit ok;
        int lat;
        ok = 1'b0;
        lat = 0;
        out_ready_w = 1'b0;
        @(negedge clk);
        x_w = xv; y_w = yv; sub_w = sv; in_valid_w = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ok = in_ready_w;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        #1;
        in_valid_w = 1'b0;
        x_w = 32'($urandom); y_w = 32'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid_w) break;
        end
        checkOutput("wide_accept", 64'(ok), 64'd1);
        checkOutput("wide_latency", 64'(lat), 64'd4);
        checkOutput("wide_z", 64'(z_w), 64'(ez));
        checkOutput("wide_flags", 64'({carry_w, sign_w, parity_w, zero_w, overflow_w}), 64'(ef));
        out_ready_w = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("wide_valid_drop", 64'(out_valid_w), 64'd0);
        checkOutput("wide_in_ready", 64'(in_ready_w), 64'd1);
    endtask

    initial begin
        logic [15:0] pick [4];
        logic [15:0] xr, yr;
        logic [15:0] held_z;
        logic [4:0]  held_f;
        checks = 0; errors = 0; accept_cyc = 0; prev_valid = 1'b0;
        in_valid = 0; x = 0; y = 0; sub = 0; out_ready = 1;
        in_valid_w = 0; x_w = 0; y_w = 0; sub_w = 0; out_ready_w = 1;
        pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h7FFF; pick[3] = 16'h8000;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_z", 64'(z), 64'd0);
        checkOutput("reset_flags", 64'({carry, sign, parity, zero, overflow}), 64'd0);
        rst_n = 1'b1;

        runDirected("add_ffff", 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 5'b01000);
        runDirected("add_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10010);
`ifdef SATURATE_EN
        runDirected("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 5'b00101);
`else
        runDirected("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01101);
`endif
        runDirected("sub_eq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 5'b10010);
        runDirected("sub_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 5'b01100);

        // Backpressure: result held for 10 cycles, then released into an immediate next accept.
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        waitValid();
        held_z = z;
        held_f = {carry, sign, parity, zero, overflow};
        repeat (10) @(negedge clk);
        checkOutput("bp_z_stable", 64'(z), 64'(held_z));
        checkOutput("bp_flags_stable", 64'({carry, sign, parity, zero, overflow}), 64'(held_f));
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_valid_drop", 64'(out_valid), 64'd0);
        checkOutput("bp_in_ready_rise", 64'(in_ready), 64'd1);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        checkOutput("bp_next_accept_cycle", 64'(cyc - accept_cyc), 64'd0);
        waitDrain();

        // Reset two cycles into an operation must abort it with no result.
        applyStimulus(16'h00FF, 16'h0101, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_z", 64'(z), 64'd0);
        checkOutput("abort_flags", 64'({carry, sign, parity, zero, overflow}), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abort_no_result", 64'(out_valid), 64'd0);
        checkOutput("abort_in_ready_after", 64'(in_ready), 64'd1);

`ifdef SATURATE_EN
        runWide(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 5'b00101);
`else
        runWide(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 5'b01101);
`endif

        // Randomized traffic with corner-biased operands and random consumer stalls.
        for (int n = 0; n < 60; n++) begin
            xr = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            yr = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            out_ready = 1'b0;
            applyStimulus(xr, yr, 1'($urandom));
            waitValid();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready = 1'b1;
            waitDrain();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
